// File: rtl/id_pkg.sv
// Shared RV32I decode constants, format classification and the decoded-instruction
// bundle used by the instruction-decode pipeline stage.
package id_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_B    = 3'b000;
   localparam logic [2:0] F3_H    = 3'b001;
   localparam logic [2:0] F3_W    = 3'b010;
   localparam logic [2:0] F3_BU   = 3'b100;
   localparam logic [2:0] F3_HU   = 3'b101;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [63:0] ZERO_WORD = '0;
   localparam logic [4:0]  ZERO_REG  = '0;

   typedef struct packed {
      logic legal;
      logic use_rs1;
      logic use_rs2;
   } fmt_t;

   // Values are carried at the widest legal XLEN; the pipe truncates to its own width.
   typedef struct packed {
      logic        reg_w_e;
      logic [4:0]  rd;
      logic        illegal;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [63:0] op1_jump;
      logic [63:0] op2_jump;
      logic [63:0] rs1_data;
      logic [63:0] rs2_data;
   } dec_t;

   function automatic fmt_t classify(input logic [31:0] inst);
      fmt_t       f;
      logic [2:0] f3;
      f3 = inst[14:12];
      f  = '0;
      case (inst[6:0])
         OPC_R: begin
            f.legal   = (inst[31:25] == F7_BASE) || (inst[31:25] == F7_ALT);
            f.use_rs1 = 1'b1;
            f.use_rs2 = 1'b1;
         end
         OPC_I: begin
            f.legal   = 1'b1;
            f.use_rs1 = 1'b1;
         end
         OPC_LOAD: begin
            f.legal   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
            f.use_rs1 = 1'b1;
         end
         OPC_STORE: begin
            f.legal   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
            f.use_rs1 = 1'b1;
            f.use_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            f.legal   = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
                        (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
            f.use_rs1 = 1'b1;
            f.use_rs2 = 1'b1;
         end
         OPC_JAL, OPC_LUI, OPC_AUIPC: f.legal = 1'b1;
         OPC_JALR: begin
            f.legal   = (f3 == F3_JALR);
            f.use_rs1 = 1'b1;
         end
         default: f = '0;
      endcase
      if (!f.legal) begin
         f = '0;
      end
      return f;
   endfunction

endpackage

// File: rtl/id_decode.sv
// Purely combinational RV32I decoder: source-register addresses plus the
// per-format operand / jump-operand bundle. Illegal encodings become a NOP.
module id_decode
   import id_pkg::*;
(
   input  logic [31:0] inst_i,
   input  logic [63:0] inst_addr_i,
   input  logic [63:0] rs1_data_i,
   input  logic [63:0] rs2_data_i,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output dec_t        dec_o
);

   fmt_t        fmt;
   logic [63:0] imm_i;
   logic [63:0] imm_s;
   logic [63:0] imm_b;
   logic [63:0] imm_u;
   logic [63:0] imm_j;

   assign fmt   = classify(inst_i);
   assign rs1_o = fmt.use_rs1 ? inst_i[19:15] : ZERO_REG;
   assign rs2_o = fmt.use_rs2 ? inst_i[24:20] : ZERO_REG;

   assign imm_i = {{52{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
   assign imm_j = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      dec_o = '0;
      if (fmt.legal) begin
         dec_o.rs1_data = fmt.use_rs1 ? rs1_data_i : ZERO_WORD;
         dec_o.rs2_data = fmt.use_rs2 ? rs2_data_i : ZERO_WORD;
         case (inst_i[6:0])
            OPC_R: begin
               dec_o.reg_w_e = 1'b1;
               dec_o.op1     = rs1_data_i;
               dec_o.op2     = rs2_data_i;
            end
            OPC_I, OPC_LOAD: begin
               dec_o.reg_w_e = 1'b1;
               dec_o.op1     = rs1_data_i;
               dec_o.op2     = imm_i;
            end
            OPC_STORE: begin
               dec_o.op1 = rs1_data_i;
               dec_o.op2 = imm_s;
            end
            OPC_BRANCH: begin
               dec_o.op1      = rs1_data_i;
               dec_o.op2      = rs2_data_i;
               dec_o.op1_jump = inst_addr_i;
               dec_o.op2_jump = imm_b;
            end
            OPC_JAL: begin
               dec_o.reg_w_e  = 1'b1;
               dec_o.op1      = inst_addr_i;
               dec_o.op2      = 64'd4;
               dec_o.op1_jump = inst_addr_i;
               dec_o.op2_jump = imm_j;
            end
            OPC_JALR: begin
               dec_o.reg_w_e  = 1'b1;
               dec_o.op1      = inst_addr_i;
               dec_o.op2      = 64'd4;
               dec_o.op1_jump = rs1_data_i;
               dec_o.op2_jump = imm_i;
            end
            OPC_LUI: begin
               dec_o.reg_w_e = 1'b1;
               dec_o.op1     = imm_u;
            end
            OPC_AUIPC: begin
               dec_o.reg_w_e = 1'b1;
               dec_o.op1     = inst_addr_i;
               dec_o.op2     = imm_u;
            end
            default: dec_o.illegal = 1'b1;
         endcase
         dec_o.rd = dec_o.reg_w_e ? inst_i[11:7] : ZERO_REG;
      end else begin
         dec_o.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/id_pipe.sv
// ID pipeline stage: valid/ready handshake, load-use stall, flush and registered decode.
// Define ID_PIPE_FWD_EN to forward non-load EX results instead of stalling on them.
module id_pipe
   import id_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        inst_i,
   input  logic [XLEN-1:0]    inst_addr_i,
   output logic [RADDR_W-1:0] reg1_r_addr_o,
   output logic [RADDR_W-1:0] reg2_r_addr_o,
   input  logic [XLEN-1:0]    reg1_r_data_i,
   input  logic [XLEN-1:0]    reg2_r_data_i,
   input  logic               flush_i,
   input  logic               ex_reg_w_e_i,
   input  logic [RADDR_W-1:0] ex_reg_w_addr_i,
   input  logic               ex_is_load_i,
   input  logic [XLEN-1:0]    ex_result_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        inst_o,
   output logic [XLEN-1:0]    inst_addr_o,
   output logic               reg_w_e_o,
   output logic [RADDR_W-1:0] reg_w_addr_o,
   output logic [XLEN-1:0]    op1_o,
   output logic [XLEN-1:0]    op2_o,
   output logic [XLEN-1:0]    op1_jump_o,
   output logic [XLEN-1:0]    op2_jump_o,
   output logic [XLEN-1:0]    reg1_r_data_o,
   output logic [XLEN-1:0]    reg2_r_data_o,
   output logic               illegal_o
);

   logic [4:0]      rs1;
   logic [4:0]      rs2;
   dec_t            dec;
   logic            hit1;
   logic            hit2;
   logic            stall;
   logic            accept;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            unused_dec;

   logic               valid_q,    valid_d;
   logic [31:0]        inst_q,     inst_d;
   logic [XLEN-1:0]    addr_q,     addr_d;
   logic               w_e_q,      w_e_d;
   logic [RADDR_W-1:0] w_addr_q,   w_addr_d;
   logic [XLEN-1:0]    op1_q,      op1_d;
   logic [XLEN-1:0]    op2_q,      op2_d;
   logic [XLEN-1:0]    op1_jump_q, op1_jump_d;
   logic [XLEN-1:0]    op2_jump_q, op2_jump_d;
   logic [XLEN-1:0]    rd1_q,      rd1_d;
   logic [XLEN-1:0]    rd2_q,      rd2_d;
   logic               illegal_q,  illegal_d;

   id_decode u_decode (
      .inst_i      (inst_i),
      .inst_addr_i (64'(inst_addr_i)),
      .rs1_data_i  (64'(src1)),
      .rs2_data_i  (64'(src2)),
      .rs1_o       (rs1),
      .rs2_o       (rs2),
      .dec_o       (dec)
   );

   assign reg1_r_addr_o = RADDR_W'(rs1);
   assign reg2_r_addr_o = RADDR_W'(rs2);

   // Unused sources decode to address 0, so the nonzero test also keeps x0 out of hazards.
   assign hit1 = ex_reg_w_e_i && (ex_reg_w_addr_i != '0) && (ex_reg_w_addr_i == RADDR_W'(rs1));
   assign hit2 = ex_reg_w_e_i && (ex_reg_w_addr_i != '0) && (ex_reg_w_addr_i == RADDR_W'(rs2));

`ifdef ID_PIPE_FWD_EN
   assign stall = ex_is_load_i && (hit1 || hit2);
   assign src1  = (hit1 && !ex_is_load_i) ? ex_result_i : reg1_r_data_i;
   assign src2  = (hit2 && !ex_is_load_i) ? ex_result_i : reg2_r_data_i;
`else
   logic unused_ex;
   assign unused_ex = ^{ex_result_i, ex_is_load_i};
   assign stall = hit1 || hit2;
   assign src1  = reg1_r_data_i;
   assign src2  = reg2_r_data_i;
`endif

   assign unused_dec = ^dec;
   assign in_ready   = !arst && (!valid_q || out_ready) && !stall && !flush_i;
   assign accept     = in_valid && in_ready;

   always_comb begin
      valid_d    = valid_q;
      inst_d     = inst_q;
      addr_d     = addr_q;
      w_e_d      = w_e_q;
      w_addr_d   = w_addr_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      op1_jump_d = op1_jump_q;
      op2_jump_d = op2_jump_q;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      illegal_d  = illegal_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         inst_d     = inst_i;
         addr_d     = inst_addr_i;
         w_e_d      = dec.reg_w_e;
         w_addr_d   = RADDR_W'(dec.rd);
         op1_d      = XLEN'(dec.op1);
         op2_d      = XLEN'(dec.op2);
         op1_jump_d = XLEN'(dec.op1_jump);
         op2_jump_d = XLEN'(dec.op2_jump);
         rd1_d      = XLEN'(dec.rs1_data);
         rd2_d      = XLEN'(dec.rs2_data);
         illegal_d  = dec.illegal;
      end else if (!valid_q || out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         valid_q    <= 1'b0;
         inst_q     <= '0;
         addr_q     <= '0;
         w_e_q      <= 1'b0;
         w_addr_q   <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         op1_jump_q <= '0;
         op2_jump_q <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         illegal_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         inst_q     <= inst_d;
         addr_q     <= addr_d;
         w_e_q      <= w_e_d;
         w_addr_q   <= w_addr_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         op1_jump_q <= op1_jump_d;
         op2_jump_q <= op2_jump_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out_valid     = valid_q;
   assign inst_o        = inst_q;
   assign inst_addr_o   = addr_q;
   assign reg_w_e_o     = w_e_q;
   assign reg_w_addr_o  = w_addr_q;
   assign op1_o         = op1_q;
   assign op2_o         = op2_q;
   assign op1_jump_o    = op1_jump_q;
   assign op2_jump_o    = op2_jump_q;
   assign reg1_r_data_o = rd1_q;
   assign reg2_r_data_o = rd2_q;
   assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: directed scenarios then random traffic against
// a behavioural ID-stage model. Honours ID_PIPE_FWD_EN the same way as the design.
module tb_id_pipe;

   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            arst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst_i;
   logic [XLEN-1:0] inst_addr_i;
   logic [RW-1:0]   reg1_r_addr_o;
   logic [RW-1:0]   reg2_r_addr_o;
   logic [XLEN-1:0] reg1_r_data_i;
   logic [XLEN-1:0] reg2_r_data_i;
   logic            flush_i;
   logic            ex_reg_w_e_i;
   logic [RW-1:0]   ex_reg_w_addr_i;
   logic            ex_is_load_i;
   logic [XLEN-1:0] ex_result_i;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     inst_o;
   logic [XLEN-1:0] inst_addr_o;
   logic            reg_w_e_o;
   logic [RW-1:0]   reg_w_addr_o;
   logic [XLEN-1:0] op1_o;
   logic [XLEN-1:0] op2_o;
   logic [XLEN-1:0] op1_jump_o;
   logic [XLEN-1:0] op2_jump_o;
   logic [XLEN-1:0] reg1_r_data_o;
   logic [XLEN-1:0] reg2_r_data_o;
   logic            illegal_o;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] j1;
      logic [31:0] j2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        ill;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   logic exp_valid;
   exp_t exp_out;
   logic last_ready;

   always #5 clk = ~clk;

   id_pipe #(.XLEN(XLEN), .RADDR_W(RW)) dut (
      .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .reg1_r_addr_o(reg1_r_addr_o), .reg2_r_addr_o(reg2_r_addr_o),
      .reg1_r_data_i(reg1_r_data_i), .reg2_r_data_i(reg2_r_data_i),
      .flush_i(flush_i), .ex_reg_w_e_i(ex_reg_w_e_i), .ex_reg_w_addr_i(ex_reg_w_addr_i),
      .ex_is_load_i(ex_is_load_i), .ex_result_i(ex_result_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .reg_w_e_o(reg_w_e_o),
      .reg_w_addr_o(reg_w_addr_o), .op1_o(op1_o), .op2_o(op2_o),
      .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
      .reg1_r_data_o(reg1_r_data_o), .reg2_r_data_o(reg2_r_data_o), .illegal_o(illegal_o)
   );

   // Register-file model: distinct value per register, x0 reads zero.
   function automatic logic [31:0] rf(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : (32'hA500_0000 | (32'(a) * 32'h0001_0101));
   endfunction

   assign reg1_r_data_i = rf(reg1_r_addr_o);
   assign reg2_r_data_i = rf(reg2_r_addr_o);

   function automatic exp_t dut_out();
      exp_t o;
      o.inst = inst_o;     o.addr = inst_addr_o; o.we = reg_w_e_o; o.wa = reg_w_addr_o;
      o.op1  = op1_o;      o.op2  = op2_o;       o.j1 = op1_jump_o; o.j2 = op2_jump_o;
      o.d1   = reg1_r_data_o; o.d2 = reg2_r_data_o; o.ill = illegal_o;
      return o;
   endfunction

   // Reference decode from the RV32I format rules, including hazard and forwarding policy.
   task automatic ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                             input logic xw, input logic xl, input logic [4:0] xa,
                             input logic [31:0] xr, output exp_t e, output logic st);
      logic signed [31:0] s;
      logic [31:0] ii, si, bi, ui, ji, a, b;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  r1, r2;
      logic        legal, u1, u2, fwd_on;
      s   = ins;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      r1  = ins[19:15]; r2 = ins[24:20];
      ii  = 32'(s >>> 20);
      si  = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
      bi  = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      ui  = ins & 32'hFFFF_F000;
      ji  = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
`ifdef ID_PIPE_FWD_EN
      fwd_on = 1'b1;
`else
      fwd_on = 1'b0;
`endif
      a = (fwd_on && xw && !xl && xa != 0 && xa == r1) ? xr : rf(r1);
      b = (fwd_on && xw && !xl && xa != 0 && xa == r2) ? xr : rf(r2);
      e = '0; legal = 1'b1; u1 = 1'b0; u2 = 1'b0;
      case (opc)
         7'h33: begin legal = (f7 == 7'h00) || (f7 == 7'h20); u1 = 1; u2 = 1; e.we = 1; e.op1 = a; e.op2 = b; end
         7'h13: begin u1 = 1; e.we = 1; e.op1 = a; e.op2 = ii; end
         7'h03: begin legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
                      u1 = 1; e.we = 1; e.op1 = a; e.op2 = ii; end
         7'h23: begin legal = (f3 <= 2); u1 = 1; u2 = 1; e.op1 = a; e.op2 = si; end
         7'h63: begin legal = (f3 != 2) && (f3 != 3); u1 = 1; u2 = 1;
                      e.op1 = a; e.op2 = b; e.j1 = pc; e.j2 = bi; end
         7'h6F: begin e.we = 1; e.op1 = pc; e.op2 = 4; e.j1 = pc; e.j2 = ji; end
         7'h67: begin legal = (f3 == 0); u1 = 1; e.we = 1; e.op1 = pc; e.op2 = 4; e.j1 = a; e.j2 = ii; end
         7'h37: begin e.we = 1; e.op1 = ui; end
         7'h17: begin e.we = 1; e.op1 = pc; e.op2 = ui; end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e = '0; e.ill = 1'b1; u1 = 1'b0; u2 = 1'b0;
      end
      e.wa   = e.we ? ins[11:7] : 5'd0;
      e.d1   = u1 ? a : 32'h0;
      e.d2   = u2 ? b : 32'h0;
      e.inst = ins;
      e.addr = pc;
      st = xw && (xa != 0) && (xl || !fwd_on) && ((u1 && xa == r1) || (u2 && xa == r2));
   endtask

   task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic xw, input logic xl,
                       input logic [4:0] xa, input logic [31:0] xr);
      exp_t e;
      logic st, rdy;
      @(negedge clk);
      in_valid = iv; inst_i = ins; inst_addr_i = pc; out_ready = ordy; flush_i = fl;
      ex_reg_w_e_i = xw; ex_is_load_i = xl; ex_reg_w_addr_i = xa; ex_result_i = xr;
      #1;
      ref_decode(ins, pc, xw, xl, xa, xr, e, st);
      rdy = (!exp_valid || ordy) && !st && !fl;
      chk("in_ready", in_ready, rdy);
      last_ready = in_ready;
      if (fl) exp_valid = 1'b0;
      else if (iv && rdy) begin exp_valid = 1'b1; exp_out = e; end
      else if (!exp_valid || ordy) exp_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, exp_valid);
      chk("fields", dut_out(), exp_out);
      $display("step t=%0t inst=%h pc=%h iv=%b ordy=%b fl=%b ex=%b/%b/%0d rdy=%b ov=%b",
               $time, ins, pc, iv, ordy, fl, xw, xl, xa, last_ready, out_valid);
   endtask

   task automatic reset_now();
      @(negedge clk);
      #2;
      arst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_fields", dut_out(), '0);
      chk("rst_in_ready", in_ready, 1'b0);
      exp_valid = 1'b0;
      exp_out   = '0;
      repeat (2) @(negedge clk);
      arst = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = int'($urandom_range(0, 9));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      case (k)
         0: begin
            w[6:0] = 7'h33;
            if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         1: w[6:0] = 7'h13;
         2: w[6:0] = 7'h03;
         3: w[6:0] = 7'h23;
         4: w[6:0] = 7'h63;
         5: w[6:0] = 7'h6F;
         6: w[6:0] = 7'h67;
         7: w[6:0] = 7'h37;
         8: w[6:0] = 7'h17;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      arst = 1'b1; in_valid = 0; inst_i = 0; inst_addr_i = 0; out_ready = 0; flush_i = 0;
      ex_reg_w_e_i = 0; ex_reg_w_addr_i = 0; ex_is_load_i = 0; ex_result_i = 0;
      exp_valid = 1'b0; exp_out = '0; last_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_fields", dut_out(), '0);
      chk("reset_in_ready", in_ready, 1'b0);
      @(negedge clk);
      arst = 1'b0;

      // addi x1,x0,5
      step(1, 32'h0050_0093, 32'h0, 1, 0, 0, 0, 0, 0);
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_op2", op2_o, 32'd5);
      chk("addi_waddr", reg_w_addr_o, 5'd1);
      chk("addi_we", reg_w_e_o, 1'b1);

      // jal x1,8 at 0x100
      step(1, 32'h0080_00EF, 32'h100, 1, 0, 0, 0, 0, 0);
      chk("jal_op1", op1_o, 32'h100);
      chk("jal_op2", op2_o, 32'd4);
      chk("jal_j1", op1_jump_o, 32'h100);
      chk("jal_j2", op2_jump_o, 32'd8);

      // lw x1,0(x2) then add x3,x1,x2 with the load in EX
      step(1, 32'h0001_2083, 32'h200, 1, 0, 0, 0, 0, 0);
      step(1, 32'h0020_81B3, 32'h204, 1, 0, 1, 1, 5'd1, 32'hDEAD);
      chk("lu_stall_ready", last_ready, 1'b0);
      chk("lu_bubble", out_valid, 1'b0);
      step(1, 32'h0020_81B3, 32'h204, 1, 0, 0, 0, 0, 0);
      chk("lu_issue_ready", last_ready, 1'b1);
      chk("lu_issue_valid", out_valid, 1'b1);
      chk("lu_issue_inst", inst_o, 32'h0020_81B3);

      // add x3,x1,x2 with a non-load EX write to x1
      step(1, 32'h0020_81B3, 32'h208, 1, 0, 1, 0, 5'd1, 32'h1234);
`ifdef ID_PIPE_FWD_EN
      chk("fwd_ready", last_ready, 1'b1);
      chk("fwd_op1", op1_o, 32'h1234);
`else
      chk("nofwd_stall", last_ready, 1'b0);
      chk("nofwd_bubble", out_valid, 1'b0);
      step(1, 32'h0020_81B3, 32'h208, 1, 0, 0, 0, 0, 0);
      chk("nofwd_issue", out_valid, 1'b1);
`endif

      // all-ones word is illegal
      step(1, 32'hFFFF_FFFF, 32'h300, 1, 0, 0, 0, 0, 0);
      chk("ill_flag", illegal_o, 1'b1);
      chk("ill_we", reg_w_e_o, 1'b0);

      // hold for three cycles, then flush
      step(1, 32'h0050_0093, 32'h400, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h0080_00EF, 32'h404, 0, 0, 0, 0, 0, 0);
         chk("hold_ready", last_ready, 1'b0);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_inst", inst_o, 32'h0050_0093);
      end
      step(1, 32'h0080_00EF, 32'h404, 0, 1, 0, 0, 0, 0);
      chk("flush_valid", out_valid, 1'b0);

      // reset while holding and stalled
      step(1, 32'h0050_0093, 32'h500, 1, 0, 0, 0, 0, 0);
      step(1, 32'h0020_81B3, 32'h504, 0, 0, 1, 1, 5'd1, 32'h0);
      reset_now();
      step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
